// File: rtl/bimodal_btb_predictor.sv
// Direct-mapped tagged BTB with per-entry saturating direction counters; optional perf counters under BPRED_PERF_EN.
// Latency: lookup is combinational, and updates are visible from the cycle after exValid.
// Backpressure: none; one update is accepted per cycle, and flushAll drops a simultaneous update.
module bimodal_btb_predictor #(
    parameter int ENTRIES  = 64,
    parameter int TAG_BITS = 8,
    parameter int CTR_BITS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fetchPc,
    output logic        fetchHit,
    output logic [31:0] fetchTarget,
    input  logic        exValid,
    input  logic [31:0] exPc,
    input  logic        exTaken,
    input  logic        exUncond,
    input  logic [31:0] exTarget,
    input  logic        exMispredict,
    input  logic        flushAll,
    output logic [31:0] perfLookups,
    output logic [31:0] perfUpdates,
    output logic [31:0] perfMispredicts
);
    localparam int IDX = $clog2(ENTRIES);
    localparam logic [CTR_BITS-1:0] CTR_ONE = CTR_BITS'(1);
    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
    localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_ONE << (CTR_BITS - 1);
    localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_WT - CTR_ONE;

    logic                validArr  [ENTRIES];
    logic [TAG_BITS-1:0] tagArr    [ENTRIES];
    logic [31:0]         targetArr [ENTRIES];
    logic [CTR_BITS-1:0] ctrArr    [ENTRIES];

    logic [IDX-1:0]      fIdx, eIdx;
    logic [TAG_BITS-1:0] fTag, eTag;
    logic                fMatch, eMatch;

    // Untranslated PC bits are deliberately ignored.
    logic unusedIn;
    assign unusedIn = &{1'b0, fetchPc, exPc, exMispredict};

    assign fIdx = fetchPc[IDX+1:2];
    assign fTag = fetchPc[IDX+1+TAG_BITS:IDX+2];
    assign eIdx = exPc[IDX+1:2];
    assign eTag = exPc[IDX+1+TAG_BITS:IDX+2];

    assign fMatch      = validArr[fIdx] && (tagArr[fIdx] == fTag);
    assign eMatch      = validArr[eIdx] && (tagArr[eIdx] == eTag);
    assign fetchHit    = fMatch && ctrArr[fIdx][CTR_BITS-1];
    assign fetchTarget = fMatch ? targetArr[fIdx] : 32'h0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                validArr[i]  <= 1'b0;
                tagArr[i]    <= '0;
                targetArr[i] <= '0;
                ctrArr[i]    <= CTR_WNT;
            end
        end else if (flushAll) begin
            // Only valid bits clear; counters and targets survive the flush.
            for (int i = 0; i < ENTRIES; i++) begin
                validArr[i] <= 1'b0;
            end
        end else if (exValid) begin
            if (eMatch) begin
                if (exUncond) begin
                    ctrArr[eIdx]    <= CTR_MAX;
                    targetArr[eIdx] <= exTarget;
                end else if (exTaken) begin
                    if (ctrArr[eIdx] != CTR_MAX) ctrArr[eIdx] <= ctrArr[eIdx] + CTR_ONE;
                    targetArr[eIdx] <= exTarget;
                end else if (ctrArr[eIdx] != '0) begin
                    ctrArr[eIdx] <= ctrArr[eIdx] - CTR_ONE;
                end
            end else if (exTaken) begin
                validArr[eIdx]  <= 1'b1;
                tagArr[eIdx]    <= eTag;
                targetArr[eIdx] <= exTarget;
                ctrArr[eIdx]    <= exUncond ? CTR_MAX : CTR_WT;
            end
        end
    end

`ifdef BPRED_PERF_EN
    logic [31:0] lookCnt, updCnt, mispCnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lookCnt <= '0;
            updCnt  <= '0;
            mispCnt <= '0;
        end else begin
            if (lookCnt != '1) lookCnt <= lookCnt + 32'd1;
            if (exValid && !flushAll && updCnt != '1) updCnt <= updCnt + 32'd1;
            if (exValid && exMispredict && mispCnt != '1) mispCnt <= mispCnt + 32'd1;
        end
    end

    assign perfLookups     = lookCnt;
    assign perfUpdates     = updCnt;
    assign perfMispredicts = mispCnt;
`else
    assign perfLookups     = '0;
    assign perfUpdates     = '0;
    assign perfMispredicts = '0;
`endif

endmodule

// File: tb/tb_bimodal_btb_predictor.sv
// Bench for bimodal_btb_predictor: directed vector table, reset corner cases, random traffic vs a behavioural model.
module tb_bimodal_btb_predictor;
    localparam int ENTRIES  = 64;
    localparam int TAG_BITS = 8;
    localparam int CTR_BITS = 2;
    localparam int IDX      = $clog2(ENTRIES);
    localparam int CMAX     = (1 << CTR_BITS) - 1;
    localparam int WT       = 1 << (CTR_BITS - 1);
`ifdef BPRED_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] fetchPc = '0;
    logic        fetchHit;
    logic [31:0] fetchTarget;
    logic        exValid = 1'b0;
    logic [31:0] exPc = '0;
    logic        exTaken = 1'b0;
    logic        exUncond = 1'b0;
    logic [31:0] exTarget = '0;
    logic        exMispredict = 1'b0;
    logic        flushAll = 1'b0;
    logic [31:0] perfLookups, perfUpdates, perfMispredicts;

    bimodal_btb_predictor #(.ENTRIES(ENTRIES), .TAG_BITS(TAG_BITS), .CTR_BITS(CTR_BITS)) dut (
        .clk(clk), .rst(rst), .fetchPc(fetchPc), .fetchHit(fetchHit), .fetchTarget(fetchTarget),
        .exValid(exValid), .exPc(exPc), .exTaken(exTaken), .exUncond(exUncond), .exTarget(exTarget),
        .exMispredict(exMispredict), .flushAll(flushAll), .perfLookups(perfLookups),
        .perfUpdates(perfUpdates), .perfMispredicts(perfMispredicts)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Behavioural model: one record per BTB slot plus event tallies.
    bit          mValid [ENTRIES];
    int unsigned mTag   [ENTRIES];
    logic [31:0] mTgt   [ENTRIES];
    int          mCtr   [ENTRIES];
    int unsigned lookCnt, updCnt, mispCnt;

    function automatic int slotOf(logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic int unsigned tagOf(logic [31:0] pc);
        return (pc >> (IDX + 2)) % (1 << TAG_BITS);
    endfunction

    function automatic logic [31:0] expPerf(int unsigned c);
        return PERF_ON ? c : 32'd0;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < ENTRIES; i++) begin
            mValid[i] = 1'b0; mTag[i] = 0; mTgt[i] = '0; mCtr[i] = WT - 1;
        end
        lookCnt = 0; updCnt = 0; mispCnt = 0;
    endtask

    task automatic modelEdge();
        int s;
        if (!rst) return;
        lookCnt++;
        if (exValid && exMispredict) mispCnt++;
        if (flushAll) begin
            for (int i = 0; i < ENTRIES; i++) mValid[i] = 1'b0;
        end else if (exValid) begin
            updCnt++;
            s = slotOf(exPc);
            if (mValid[s] && mTag[s] == tagOf(exPc)) begin
                if (exUncond) begin
                    mCtr[s] = CMAX; mTgt[s] = exTarget;
                end else if (exTaken) begin
                    mCtr[s] = (mCtr[s] + 1 > CMAX) ? CMAX : mCtr[s] + 1; mTgt[s] = exTarget;
                end else begin
                    mCtr[s] = (mCtr[s] > 0) ? mCtr[s] - 1 : 0;
                end
            end else if (exTaken) begin
                mValid[s] = 1'b1; mTag[s] = tagOf(exPc); mTgt[s] = exTarget;
                mCtr[s] = exUncond ? CMAX : WT;
            end
        end
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chkPerf(string tag);
        chk({tag, " perfLookups"}, perfLookups, expPerf(lookCnt));
        chk({tag, " perfUpdates"}, perfUpdates, expPerf(updCnt));
        chk({tag, " perfMispredicts"}, perfMispredicts, expPerf(mispCnt));
    endtask

    task automatic chkModel(string tag);
        int s;
        bit hit;
        s = slotOf(fetchPc);
        hit = mValid[s] && (mTag[s] == tagOf(fetchPc));
        chk({tag, " fetchHit"}, {31'd0, fetchHit}, {31'd0, hit && (mCtr[s] >= WT)});
        chk({tag, " fetchTarget"}, fetchTarget, hit ? mTgt[s] : 32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic        tk;
        logic        un;
        logic [31:0] tg;
        logic        fl;
        logic [31:0] fpc;
        logic        eh;
        logic [31:0] et;
    } vec_t;

    localparam int NV = 31;
    vec_t vecs [NV];

    function automatic vec_t mk(logic v, logic [31:0] pc, logic tk, logic un, logic [31:0] tg,
                                logic fl, logic [31:0] fpc, logic eh, logic [31:0] et);
        vec_t r;
        r.v = v; r.pc = pc; r.tk = tk; r.un = un; r.tg = tg;
        r.fl = fl; r.fpc = fpc; r.eh = eh; r.et = et;
        return r;
    endfunction

    function automatic logic [31:0] randPc();
        logic [31:0] p;
        p = ($urandom_range(0, 3) << (IDX + 2)) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
        if ($urandom_range(0, 7) == 0) p |= $urandom & ~((32'h1 << (IDX + 2 + TAG_BITS)) - 32'h1);
        return p;
    endfunction

    initial begin
        // Each row is one cycle; expected outputs are the lookup seen during that cycle.
        vecs[0]  = mk(0, 32'h0,    0, 0, 32'h0,   0, 32'h100,  0, 32'h0);
        vecs[1]  = mk(0, 32'h0,    0, 0, 32'h0,   0, 32'h2000, 0, 32'h0);
        vecs[2]  = mk(1, 32'h100,  1, 0, 32'h240, 0, 32'h100,  0, 32'h0);
        vecs[3]  = mk(0, 32'h0,    0, 0, 32'h0,   0, 32'h100,  1, 32'h240);
        vecs[4]  = mk(1, 32'h100,  0, 0, 32'h0,   0, 32'h100,  1, 32'h240);
        vecs[5]  = mk(0, 32'h0,    0, 0, 32'h0,   0, 32'h100,  0, 32'h240);
        vecs[6]  = mk(1, 32'h100,  1, 0, 32'h240, 0, 32'h100,  0, 32'h240);
        vecs[7]  = mk(0, 32'h0,    0, 0, 32'h0,   0, 32'h100,  1, 32'h240);
        vecs[8]  = mk(1, 32'h100,  1, 0, 32'h240, 0, 32'h100,  1, 32'h240);
        vecs[9]  = mk(1, 32'h100,  1, 0, 32'h240, 0, 32'h100,  1, 32'h240);
        vecs[10] = mk(1, 32'h100,  1, 0, 32'h240, 0, 32'h100,  1, 32'h240);
        vecs[11] = mk(1, 32'h100,  0, 0, 32'h0,   0, 32'h100,  1, 32'h240);
        vecs[12] = mk(0, 32'h0,    0, 0, 32'h0,   0, 32'h100,  1, 32'h240);
        vecs[13] = mk(0, 32'h0,    0, 0, 32'h0,   0, 32'h200,  0, 32'h0);
        vecs[14] = mk(1, 32'h200,  1, 0, 32'h400, 0, 32'h200,  0, 32'h0);
        vecs[15] = mk(0, 32'h0,    0, 0, 32'h0,   0, 32'h200,  1, 32'h400);
        vecs[16] = mk(0, 32'h0,    0, 0, 32'h0,   0, 32'h100,  0, 32'h0);
        vecs[17] = mk(1, 32'h80,   1, 1, 32'h10,  0, 32'h80,   0, 32'h0);
        vecs[18] = mk(0, 32'h0,    0, 0, 32'h0,   0, 32'h80,   1, 32'h10);
        vecs[19] = mk(1, 32'h300,  1, 0, 32'h500, 1, 32'h80,   1, 32'h10);
        vecs[20] = mk(0, 32'h0,    0, 0, 32'h0,   0, 32'h80,   0, 32'h0);
        vecs[21] = mk(0, 32'h0,    0, 0, 32'h0,   0, 32'h300,  0, 32'h0);
        vecs[22] = mk(0, 32'h0,    0, 0, 32'h0,   0, 32'h200,  0, 32'h0);
        vecs[23] = mk(1, 32'h40,   1, 0, 32'h44,  0, 32'h40,   0, 32'h0);
        vecs[24] = mk(1, 32'h40,   0, 0, 32'h0,   0, 32'h40,   1, 32'h44);
        vecs[25] = mk(1, 32'h40,   0, 0, 32'h0,   0, 32'h40,   0, 32'h44);
        vecs[26] = mk(1, 32'h40,   0, 0, 32'h0,   0, 32'h40,   0, 32'h44);
        vecs[27] = mk(1, 32'h40,   1, 0, 32'h44,  0, 32'h40,   0, 32'h44);
        vecs[28] = mk(0, 32'h0,    0, 0, 32'h0,   0, 32'h40,   0, 32'h44);
        vecs[29] = mk(1, 32'h1000, 0, 0, 32'h0,   0, 32'h1000, 0, 32'h0);
        vecs[30] = mk(0, 32'h0,    0, 0, 32'h0,   0, 32'h1000, 0, 32'h0);

        modelReset();
        fetchPc = 32'h100;
        #2;
        chk("reset fetchHit", {31'd0, fetchHit}, 32'd0);
        chk("reset fetchTarget", fetchTarget, 32'h0);
        chkPerf("reset");
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;

        for (int r = 0; r < NV; r++) begin
            exValid = vecs[r].v; exPc = vecs[r].pc; exTaken = vecs[r].tk; exUncond = vecs[r].un;
            exTarget = vecs[r].tg; flushAll = vecs[r].fl; fetchPc = vecs[r].fpc;
            exMispredict = vecs[r].v & vecs[r].tk;
            @(negedge clk);
            chk($sformatf("vec%0d fetchHit", r), {31'd0, fetchHit}, {31'd0, vecs[r].eh});
            chk($sformatf("vec%0d fetchTarget", r), fetchTarget, vecs[r].et);
            if (r == 9) chkPerf("vec9");
            tick();
        end
        exValid = 1'b0; flushAll = 1'b0; exMispredict = 1'b0;
        chkPerf("table end");

        // Asynchronous reset mid-cycle while 0x40 still returns a target.
        fetchPc = 32'h40;
        #1;
        chk("pre-reset fetchTarget", fetchTarget, 32'h44);
        rst = 1'b0;
        #1;
        modelReset();
        chk("async reset fetchTarget", fetchTarget, 32'h0);
        chk("async reset fetchHit", {31'd0, fetchHit}, 32'd0);
        chkPerf("async reset");
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("post-reset fetchTarget", fetchTarget, 32'h0);
        tick();

        for (int c = 0; c < 600; c++) begin
            exValid = ($urandom_range(0, 2) != 0);
            exPc = randPc();
            exUncond = ($urandom_range(0, 5) == 0);
            exTaken = exUncond | ($urandom_range(0, 2) != 0);
            exTarget = $urandom;
            exMispredict = $urandom_range(0, 1);
            flushAll = ($urandom_range(0, 40) == 0);
            fetchPc = $urandom_range(0, 1) ? exPc : randPc();
            @(negedge clk);
            chkModel($sformatf("rand%0d", c));
            if (c % 100 == 99) chkPerf($sformatf("rand%0d", c));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
